// File: rtl/fxu_pkg.sv
// Shared FXU types: opcode constants, datapath widths, entry/operand structs.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fxu_pkg;

  localparam int DATA_W = 16;
  localparam int ROB_W  = 4;
  localparam int IMM_W  = 8;
  localparam int OPC_W  = 4;

  localparam logic [OPC_W-1:0] OP_ADD  = 4'b0000;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'b0001;
  localparam logic [OPC_W-1:0] OP_MOV  = 4'b0100;
  localparam logic [OPC_W-1:0] OP_MOVL = 4'b0101;
  localparam logic [OPC_W-1:0] OP_MOVH = 4'b0110;

  // When rdy=0, val[ROB_W-1:0] holds the producer ROB tag.
  typedef struct packed {
    logic              rdy;
    logic [DATA_W-1:0] val;
  } operand_t;

  // Per-entry control fields; operands live in rs_operand instances.
  typedef struct packed {
    logic             vld;
    logic [OPC_W-1:0] opcode;
    logic [ROB_W-1:0] rob;
    logic [IMM_W-1:0] imm;
  } entry_t;

endpackage

// File: rtl/rs_operand.sv
// One operand slot: registers its incoming operand, capturing the CDB value when
// a pending tag matches. Latency: 1 cycle (wakeup visible after the edge).
// Backpressure: none; the parent selects hold/shift/dispatch input every cycle.
// Ports: op_in (next-cycle source operand), cdb_* (broadcast), op_o (registered operand).
module rs_operand
  import fxu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  operand_t          op_in,
  input  logic              cdb_valid,
  input  logic [ROB_W-1:0]  cdb_rob,
  input  logic [DATA_W-1:0] cdb_value,
  output operand_t          op_o
);

  operand_t op_q;
  operand_t op_d;

  always_comb begin
    op_d = op_in;
    if (!op_in.rdy && cdb_valid && (op_in.val[ROB_W-1:0] == cdb_rob)) begin
      op_d.rdy = 1'b1;
      op_d.val = cdb_value;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) op_q <= '0;
    else        op_q <= op_d;
  end

  assign op_o = op_q;

endmodule

// File: rtl/fxu_rs.sv
// FXU reservation station: collapsing queue of DEPTH entries, oldest-ready issue.
// Latency: dispatch or CDB wakeup at edge N makes an entry issuable from N+1.
// Backpressure: disp_ready=0 when full (no same-cycle issue credit); issue holds until iss_ready.
// Ports: clk/rst_n/flush, disp_* (dispatch in), cdb_* (wakeup bus), iss_* (issue out).
module fxu_rs
  import fxu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  logic [OPC_W-1:0]  disp_opcode,
  input  logic [ROB_W-1:0]  disp_rob,
  input  logic [IMM_W-1:0]  disp_imm,
  input  logic              disp_t_rdy,
  input  logic              disp_a_rdy,
  input  logic              disp_b_rdy,
  input  logic [DATA_W-1:0] disp_t_val,
  input  logic [DATA_W-1:0] disp_a_val,
  input  logic [DATA_W-1:0] disp_b_val,
  input  logic              cdb_valid,
  input  logic [ROB_W-1:0]  cdb_rob,
  input  logic [DATA_W-1:0] cdb_value,
  output logic              iss_valid,
  input  logic              iss_ready,
  output logic [OPC_W-1:0]  iss_opcode,
  output logic [ROB_W-1:0]  iss_rob,
  output logic [IMM_W-1:0]  iss_imm,
  output logic [DATA_W-1:0] iss_vt,
  output logic [DATA_W-1:0] iss_va,
  output logic [DATA_W-1:0] iss_vb
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  entry_t   ent_q   [DEPTH];
  entry_t   ent_d   [DEPTH];
  operand_t opr_q   [DEPTH][3];
  operand_t opr_in  [DEPTH][3];
  // One zero slot past the end so "shift from i+1" is always in range.
  entry_t   ent_ext [DEPTH+1];
  operand_t opr_ext [DEPTH+1][3];

  logic [CNT_W-1:0] occ;
  logic [CNT_W-1:0] iss_sel;
  logic [CNT_W-1:0] wr_slot;
  logic             issue_fire;
  logic             disp_fire;

  // Occupancy and oldest-ready selection; scanning high-to-low lets the
  // lowest ready index win. Packet is zero whenever nothing is issuable.
  always_comb begin
    occ        = '0;
    iss_sel    = '0;
    iss_valid  = 1'b0;
    iss_opcode = '0;
    iss_rob    = '0;
    iss_imm    = '0;
    iss_vt     = '0;
    iss_va     = '0;
    iss_vb     = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_q[i].vld) occ = occ + 1'b1;
      if (ent_q[i].vld && opr_q[i][0].rdy && opr_q[i][1].rdy && opr_q[i][2].rdy) begin
        iss_valid  = 1'b1;
        iss_sel    = CNT_W'(i);
        iss_opcode = ent_q[i].opcode;
        iss_rob    = ent_q[i].rob;
        iss_imm    = ent_q[i].imm;
        iss_vt     = opr_q[i][0].val;
        iss_va     = opr_q[i][1].val;
        iss_vb     = opr_q[i][2].val;
      end
    end
  end

  assign disp_ready = (occ < CNT_W'(DEPTH));
  assign issue_fire = iss_valid & iss_ready & ~flush;
  assign disp_fire  = disp_valid & disp_ready & ~flush;
  assign wr_slot    = occ - CNT_W'(issue_fire);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_ext[i] = ent_q[i];
      for (int k = 0; k < 3; k++) opr_ext[i][k] = opr_q[i][k];
    end
    ent_ext[DEPTH] = '0;
    for (int k = 0; k < 3; k++) opr_ext[DEPTH][k] = '0;
  end

  // Per slot: hold, or take the next-younger slot when at/above the issued
  // entry; the dispatch slot is overwritten. CDB wakeup of whatever lands in a
  // slot happens inside rs_operand, covering held, shifted and new operands.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (issue_fire && (CNT_W'(i) >= iss_sel)) begin
        ent_d[i] = ent_ext[i+1];
        for (int k = 0; k < 3; k++) opr_in[i][k] = opr_ext[i+1][k];
      end else begin
        ent_d[i] = ent_ext[i];
        for (int k = 0; k < 3; k++) opr_in[i][k] = opr_ext[i][k];
      end
      if (disp_fire && (CNT_W'(i) == wr_slot)) begin
        ent_d[i].vld    = 1'b1;
        ent_d[i].opcode = disp_opcode;
        ent_d[i].rob    = disp_rob;
        ent_d[i].imm    = disp_imm;
        opr_in[i][0]    = '{rdy: disp_t_rdy, val: disp_t_val};
        opr_in[i][1]    = '{rdy: disp_a_rdy, val: disp_a_val};
        opr_in[i][2]    = '{rdy: disp_b_rdy, val: disp_b_val};
      end
      if (flush) ent_d[i].vld = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    for (genvar k = 0; k < 3; k++) begin : g_opr
      rs_operand u_opr (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_in     (opr_in[g][k]),
        .cdb_valid (cdb_valid),
        .cdb_rob   (cdb_rob),
        .cdb_value (cdb_value),
        .op_o      (opr_q[g][k])
      );
    end
  end

endmodule

// File: tb/tb_fxu_rs.sv
// Self-checking bench for fxu_rs: directed scenarios then randomized traffic
// compared every cycle against a queue-based reference model.
module tb_fxu_rs;
  import fxu_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush, disp_valid, disp_ready;
  logic [3:0]  disp_opcode, disp_rob;
  logic [7:0]  disp_imm;
  logic        disp_t_rdy, disp_a_rdy, disp_b_rdy;
  logic [15:0] disp_t_val, disp_a_val, disp_b_val;
  logic        cdb_valid;
  logic [3:0]  cdb_rob;
  logic [15:0] cdb_value;
  logic        iss_valid, iss_ready;
  logic [3:0]  iss_opcode, iss_rob;
  logic [7:0]  iss_imm;
  logic [15:0] iss_vt, iss_va, iss_vb;

  always #5 clk = ~clk;

  fxu_rs #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_opcode(disp_opcode), .disp_rob(disp_rob), .disp_imm(disp_imm),
    .disp_t_rdy(disp_t_rdy), .disp_a_rdy(disp_a_rdy), .disp_b_rdy(disp_b_rdy),
    .disp_t_val(disp_t_val), .disp_a_val(disp_a_val), .disp_b_val(disp_b_val),
    .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_value(cdb_value),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_opcode(iss_opcode), .iss_rob(iss_rob), .iss_imm(iss_imm),
    .iss_vt(iss_vt), .iss_va(iss_va), .iss_vb(iss_vb)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: an age-ordered queue; index 0 is the oldest.
  typedef struct packed {
    logic [3:0]       opc;
    logic [3:0]       rob;
    logic [7:0]       imm;
    logic [2:0]       rdy;   // [0]=t [1]=a [2]=b
    logic [2:0][15:0] val;
  } m_ent_t;

  m_ent_t mq[$];

  function automatic int m_first_ready();
    for (int i = 0; i < mq.size(); i++) if (&mq[i].rdy) return i;
    return -1;
  endfunction

  function automatic m_ent_t m_wake(input m_ent_t e);
    m_ent_t r = e;
    for (int k = 0; k < 3; k++)
      if (!r.rdy[k] && cdb_valid && (r.val[k][3:0] == cdb_rob)) begin
        r.rdy[k] = 1'b1;
        r.val[k] = cdb_value;
      end
    return r;
  endfunction

  task automatic model_step();
    int     f;
    logic   dfire;
    m_ent_t e;
    if (!rst_n || flush) begin
      mq.delete();
      return;
    end
    dfire = disp_valid && (mq.size() < DEPTH);
    f = m_first_ready();
    if (f >= 0 && iss_ready) mq.delete(f);
    for (int i = 0; i < mq.size(); i++) mq[i] = m_wake(mq[i]);
    if (dfire) begin
      e.opc = disp_opcode; e.rob = disp_rob; e.imm = disp_imm;
      e.rdy = {disp_b_rdy, disp_a_rdy, disp_t_rdy};
      e.val = {disp_b_val, disp_a_val, disp_t_val};
      mq.push_back(m_wake(e));
    end
  endtask

  task automatic compare_all();
    int     f = m_first_ready();
    m_ent_t e = '0;
    if (f >= 0) e = mq[f];
    check("disp_ready", 32'(disp_ready), 32'(mq.size() < DEPTH));
    check("iss_valid",  32'(iss_valid),  32'(f >= 0));
    check("iss_opcode", 32'(iss_opcode), 32'(e.opc));
    check("iss_rob",    32'(iss_rob),    32'(e.rob));
    check("iss_imm",    32'(iss_imm),    32'(e.imm));
    check("iss_vt",     32'(iss_vt),     32'(e.val[0]));
    check("iss_va",     32'(iss_va),     32'(e.val[1]));
    check("iss_vb",     32'(iss_vb),     32'(e.val[2]));
  endtask

  // Compare at the falling edge, advance the model, then step past the rising edge.
  task automatic do_cycle();
    @(negedge clk);
    compare_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 1'b0; disp_valid = 1'b0; cdb_valid = 1'b0;
    disp_opcode = '0; disp_rob = '0; disp_imm = '0;
    disp_t_rdy = 1'b0; disp_a_rdy = 1'b0; disp_b_rdy = 1'b0;
    disp_t_val = '0; disp_a_val = '0; disp_b_val = '0;
    cdb_rob = '0; cdb_value = '0;
  endtask

  task automatic disp(input logic [3:0] opc, input logic [3:0] rob, input logic [7:0] imm,
                      input logic tr, input logic [15:0] tv, input logic ar, input logic [15:0] av,
                      input logic br, input logic [15:0] bv);
    disp_valid = 1'b1; disp_opcode = opc; disp_rob = rob; disp_imm = imm;
    disp_t_rdy = tr; disp_t_val = tv; disp_a_rdy = ar; disp_a_val = av;
    disp_b_rdy = br; disp_b_val = bv;
  endtask

  task automatic cdb(input logic [3:0] rob, input logic [15:0] value);
    cdb_valid = 1'b1; cdb_rob = rob; cdb_value = value;
  endtask

  initial begin
    idle();
    iss_ready = 1'b0;
    #3;
    check("rst_iss_valid", 32'(iss_valid), 32'd0);
    check("rst_disp_ready", 32'(disp_ready), 32'd1);
    check("rst_iss_rob", 32'(iss_rob), 32'd0);
    check("rst_iss_va", 32'(iss_va), 32'd0);
    do_cycle();
    do_cycle();
    rst_n = 1'b1;
    do_cycle();

    // ADD rob 3, a=5 b=7 all ready -> issues next cycle, then empty.
    iss_ready = 1'b1;
    disp(OP_ADD, 4'd3, 8'h00, 1'b1, 16'h0, 1'b1, 16'd5, 1'b1, 16'd7);
    do_cycle();
    idle();
    check("add_valid", 32'(iss_valid), 32'd1);
    check("add_rob", 32'(iss_rob), 32'd3);
    check("add_va", 32'(iss_va), 32'd5);
    check("add_vb", 32'(iss_vb), 32'd7);
    do_cycle();
    check("add_empty", 32'(iss_valid), 32'd0);

    // SUB rob 2, a waits on tag 9; CDB two cycles later.
    disp(OP_SUB, 4'd2, 8'h00, 1'b1, 16'h0, 1'b0, 16'h0009, 1'b1, 16'd3);
    do_cycle();
    idle();
    check("sub_wait0", 32'(iss_valid), 32'd0);
    do_cycle();
    check("sub_wait1", 32'(iss_valid), 32'd0);
    cdb(4'd9, 16'h0040);
    do_cycle();
    idle();
    check("sub_valid", 32'(iss_valid), 32'd1);
    check("sub_va", 32'(iss_va), 32'h0040);
    check("sub_rob", 32'(iss_rob), 32'd2);
    do_cycle();

    // Fill with iss_ready=0, try a 5th, then drain oldest first.
    iss_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp(OP_MOV, 4'(4 + i), 8'(i), 1'b1, 16'h0, 1'b1, 16'(i), 1'b1, 16'h0);
      do_cycle();
    end
    check("full_ready", 32'(disp_ready), 32'd0);
    check("full_rob", 32'(iss_rob), 32'd4);
    disp(OP_ADD, 4'd8, 8'h00, 1'b1, 16'h0, 1'b1, 16'h0, 1'b1, 16'h0);
    do_cycle();
    idle();
    check("full_hold_rob", 32'(iss_rob), 32'd4);
    check("full_hold_ready", 32'(disp_ready), 32'd0);
    iss_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_rob", 32'(iss_rob), 32'(4 + i));
      do_cycle();
    end
    check("drain_empty", 32'(iss_valid), 32'd0);

    // MOV with a waiting on tag 6 while CDB broadcasts tag 6 in the same cycle.
    iss_ready = 1'b0;
    disp(OP_MOV, 4'd1, 8'h00, 1'b1, 16'h0, 1'b0, 16'h0006, 1'b1, 16'h0);
    cdb(4'd6, 16'h1234);
    do_cycle();
    idle();
    check("byp_valid", 32'(iss_valid), 32'd1);
    check("byp_va", 32'(iss_va), 32'h1234);
    iss_ready = 1'b1;
    do_cycle();

    // Three pending entries, then flush with a simultaneous dispatch.
    iss_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      disp(OP_SUB, 4'(10 + i), 8'h00, 1'b1, 16'h0, 1'b0, 16'h000f, 1'b1, 16'h0);
      do_cycle();
    end
    idle();
    flush = 1'b1;
    iss_ready = 1'b1;
    disp(OP_ADD, 4'd13, 8'h00, 1'b1, 16'h0, 1'b1, 16'h0, 1'b1, 16'h0);
    do_cycle();
    idle();
    check("flush_valid", 32'(iss_valid), 32'd0);
    check("flush_ready", 32'(disp_ready), 32'd1);
    do_cycle();

    // Asynchronous reset with two ready entries.
    iss_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      disp(OP_MOVL, 4'(i), 8'hA5, 1'b1, 16'h1111, 1'b1, 16'h2222, 1'b1, 16'h3333);
      do_cycle();
    end
    idle();
    check("pre_arst_valid", 32'(iss_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    mq.delete();
    check("arst_valid", 32'(iss_valid), 32'd0);
    check("arst_vt", 32'(iss_vt), 32'd0);
    check("arst_imm", 32'(iss_imm), 32'd0);
    check("arst_ready", 32'(disp_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_cycle();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      idle();
      if ($urandom_range(0, 9) < 6)
        disp(4'($urandom()), 4'($urandom()), 8'($urandom()),
             $urandom_range(0, 1) == 1, 16'($urandom()),
             $urandom_range(0, 1) == 1, 16'($urandom()),
             $urandom_range(0, 1) == 1, 16'($urandom()));
      if ($urandom_range(0, 9) < 4) cdb(4'($urandom()), 16'($urandom()));
      iss_ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 99) < 3);
      do_cycle();
    end
    idle();
    do_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fxu_rs.md
FXU_RS -- requirements
Module: fxu_rs

Interface
REQ-001 Parameter DEPTH, default 4, is the number of reservation-station entries; legal values are 2..8.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 flush  input  1  discards every entry (mispredict or exception recovery).
REQ-005 disp_valid  input  1  dispatch request.
REQ-006 disp_ready  output  1  station can accept a dispatch this cycle.
REQ-007 disp_opcode  input  4  FXU opcode: ADD 0000, SUB 0001, MOV 0100, MOVL 0101, MOVH 0110.
REQ-008 disp_rob  input  4  ROB index of the instruction.
REQ-009 disp_imm  input  8  immediate for MOVL/MOVH.
REQ-010 disp_t_rdy / disp_a_rdy / disp_b_rdy  input  1 each  operand already available.
REQ-011 disp_t_val / disp_a_val / disp_b_val  input  16 each  operand value if rdy=1, else producer ROB tag in bits [3:0].
REQ-012 cdb_valid  input  1  result broadcast on the common data bus.
REQ-013 cdb_rob  input  4  ROB index of the broadcast result.
REQ-014 cdb_value  input  16  broadcast value.
REQ-015 iss_valid  output  1  issue packet to FXU is valid.
REQ-016 iss_ready  input  1  FXU/CDB slot accepts the packet.
REQ-017 iss_opcode / iss_rob / iss_imm  output  4 / 4 / 8  issued fields.
REQ-018 iss_vt / iss_va / iss_vb  output  16 each  issued operand values.

Function
REQ-019 Dispatch is accepted on the clock edge where disp_valid=1 and disp_ready=1.
REQ-020 disp_ready SHALL be 1 iff occupancy < DEPTH, with no credit for a same-cycle issue.
REQ-021 The dispatcher marks unused operands rdy=1; the station treats all three operands uniformly.
REQ-022 Entries form a collapsing queue: entry 0 is the oldest; on issue, younger entries shift down one slot in the same edge.
REQ-023 A new entry is written at slot (occupancy minus issued-this-cycle).
REQ-024 Wakeup: an entry whose pending operand tag equals cdb_rob while cdb_valid=1 captures cdb_value and sets rdy.
REQ-025 Wakeup also applies to a dispatching operand in the same cycle: it is stored ready with cdb_value.
REQ-026 Wakeup also applies to an entry shifting in the same cycle.
REQ-027 iss_valid=1 iff some valid entry has all three operands ready, evaluated on registered state only (no same-cycle CDB bypass).
REQ-028 The issue packet is the lowest-index (oldest) fully ready entry; iss_* outputs are combinational from entry state.
REQ-029 The entry is removed when iss_valid=1 and iss_ready=1; iss_* SHALL stay stable while iss_valid=1 and iss_ready=0, absent flush or a CDB update.
REQ-030 Latency: dispatch with all operands ready at edge N gives iss_valid from N+1; CDB wakeup at edge N gives eligibility from N+1.
REQ-031 At most one dispatch and one issue per cycle.
REQ-032 Opcode is stored unchecked; legality is the FXU's concern.
REQ-033 flush=1 invalidates all entries at the edge, takes priority over a same-cycle dispatch, drops that dispatch, and no issue handshake completes that cycle.
REQ-034 At full occupancy, issue and flush proceed normally; dispatch stalls via disp_ready=0.

Reset
REQ-035 While rst_n=0: all entries invalid, occupancy 0, iss_valid=0, iss_* all zero, disp_ready=1.
REQ-036 Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.

Structure
REQ-037 Package fxu_pkg SHALL hold the opcode constants, DATA_W=16, ROB_W=4, IMM_W=8, and the entry/operand struct types, shared with the FXU.
REQ-038 Sub-module rs_operand (value, rdy, tag match/capture) SHALL be instantiated three times per entry.

Verification
REQ-039 Dispatch ADD rob 3 with a=5, b=7, both ready, iss_ready=1 -> iss_valid the next cycle, iss_rob=3, va=5, vb=7, station then empty.
REQ-040 Dispatch SUB rob 2 with a waiting on tag 9; CDB rob 9 value 0x0040 two cycles later -> issue one cycle after the broadcast with va=0x0040.
REQ-041 Fill 4 entries with iss_ready=0 -> disp_ready=0, a 5th dispatch is not accepted, oldest entry held stable; iss_ready=1 -> issues drain oldest-first.
REQ-042 Dispatch MOV with a waiting on tag 6 while cdb_valid=1 and cdb_rob=6 value 0x1234 in the same cycle -> entry issues next cycle with va=0x1234.
REQ-043 Three entries pending, then flush with a simultaneous dispatch -> station empty next cycle, no issue, disp_ready=1.
REQ-044 rst_n dropped asynchronously with 2 ready entries -> iss_valid falls immediately, all outputs zero.
